// File: rtl/sap_full_system_pkg.sv
// Shared sizes, opcodes, constants and small helpers for the SAP system.
// Build option: SAP_POCA_EN enables the POCA opcode (see sap_full_system).
package sap_full_system_pkg;

    localparam int unsigned HOST_INSTRUCT_SIZE   = 6;
    localparam int unsigned MAX_INPUT_DATA_SIZE  = 512;
    localparam int unsigned MAX_OUTPUT_DATA_SIZE = 512;
    localparam int unsigned POCA_MULT_SIZE       = 283;
    localparam int unsigned POCA_HASH_SIZE       = 256;
    localparam int unsigned POCA_SEED_SIZE       = 128;
    localparam int unsigned POCA_CYCLE_SIZE      = 32;
    localparam int unsigned POCA_ASSET_SIZE      = 11;
    localparam int unsigned POCA_RESP_SIZE       = POCA_MULT_SIZE + POCA_HASH_SIZE;

    localparam logic [HOST_INSTRUCT_SIZE-1:0] OP_ENCRYPT    = 6'h11;
    localparam logic [HOST_INSTRUCT_SIZE-1:0] OP_DECRYPT    = 6'h12;
    localparam logic [HOST_INSTRUCT_SIZE-1:0] OP_HASH       = 6'h13;
    localparam logic [HOST_INSTRUCT_SIZE-1:0] OP_TRNG       = 6'h14;
    localparam logic [HOST_INSTRUCT_SIZE-1:0] OP_ODOMETER   = 6'h17;
    localparam logic [HOST_INSTRUCT_SIZE-1:0] OP_PUF        = 6'h25;
    localparam logic [HOST_INSTRUCT_SIZE-1:0] OP_MEM_WRITE  = 6'h26;
    localparam logic [HOST_INSTRUCT_SIZE-1:0] OP_PUF_VERIFY = 6'h29;
    localparam logic [HOST_INSTRUCT_SIZE-1:0] OP_MEM_READ   = 6'h2A;
    localparam logic [HOST_INSTRUCT_SIZE-1:0] OP_SEC_PUF    = 6'h2B;
    localparam logic [HOST_INSTRUCT_SIZE-1:0] OP_POCA       = 6'h2C;

    localparam logic [63:0] PUF_CONST = 64'h5A5AC3C30F0F9696;
    localparam logic [31:0] LFSR_SEED = 32'hACE12468;
    localparam logic [31:0] LFSR_TAPS = 32'h80200003;

    typedef enum logic [2:0] {
        ST_IDLE, ST_RUN, ST_WAIT_KEY, ST_WAIT_DATA, ST_DONE
    } sap_state_e;

    typedef enum logic [1:0] {CR_ENC, CR_DEC, CR_HASH} crypto_op_e;

    function automatic logic [127:0] rotl128(input logic [127:0] x, input int n);
        return (x << n) | (x >> (128 - n));
    endfunction

    function automatic logic [127:0] rotr128(input logic [127:0] x, input int n);
        return (x >> n) | (x << (128 - n));
    endfunction

    function automatic logic [255:0] rotl256(input logic [255:0] x, input int n);
        return (x << n) | (x >> (256 - n));
    endfunction

    // Variable rotate: the upper half of the doubled word shifted left is rotl.
    function automatic logic [63:0] puf_resp(input logic [63:0] c);
        logic [127:0] dbl;
        dbl = {c ^ PUF_CONST, c ^ PUF_CONST} << c[5:0];
        return dbl[127:64];
    endfunction

    // Right-shifting Galois step.
    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return {1'b0, x[31:1]} ^ (x[0] ? LFSR_TAPS : 32'd0);
    endfunction

    // 16-bit fold of seed and asset size, spread over 16 words each tagged by its index.
    function automatic logic [255:0] hash16(input logic [127:0] seed, input logic [10:0] asset);
        logic [15:0]  h;
        logic [255:0] d;
        h = {5'b0, asset};
        for (int i = 0; i < 8; i++) h = {h[14:0], h[15]} ^ seed[16*i +: 16];
        for (int i = 0; i < 16; i++) d[16*i +: 16] = h ^ 16'(i);
        return d;
    endfunction

endpackage

// File: rtl/sap_full_system_crypto_core.sv
// sap_crypto_core: combinational single-round logic for cipher, hash and PUF.
// Ports: op_sel/round select the round; state_in/key_in are the working
// registers; hash_data is the hash operand; key0 seeds the decrypt key
// derivation; challenge feeds the PUF. All outputs are combinational (_c).
module sap_crypto_core
    import sap_full_system_pkg::*;
(
    input  logic [1:0]   op_sel,
    input  logic [2:0]   round,
    input  logic [255:0] state_in,
    input  logic [127:0] key_in,
    input  logic [511:0] hash_data,
    input  logic [127:0] key0,
    input  logic [63:0]  challenge,
    output logic [255:0] state_c,
    output logic [127:0] key_c,
    output logic [127:0] key_last_c,
    output logic [63:0]  puf_resp_c
);

    // One round of the selected algorithm.
    always_comb begin
        state_c = state_in;
        key_c   = key_in;
        case (op_sel)
            CR_ENC: begin
                state_c = {128'b0, rotl128(state_in[127:0] ^ key_in, 8)};
                key_c   = rotl128(key_in, 1) ^ 128'(round);
            end
            CR_DEC: begin
                // Walk the key schedule backwards: k_{r-1} = rotr(k_r ^ (r-1), 1).
                state_c = {128'b0, rotr128(state_in[127:0], 8) ^ key_in};
                key_c   = rotr128(key_in ^ 128'(round - 3'd1), 1);
            end
            CR_HASH: state_c = rotl256(state_in ^ hash_data[255:0], 13) + hash_data[511:256];
            default: ;
        endcase
    end

    // k3 from k0, so decryption can start at the last round key.
    always_comb begin
        key_last_c = rotl128(key0, 1);
        key_last_c = rotl128(key_last_c, 1) ^ 128'd1;
        key_last_c = rotl128(key_last_c, 1) ^ 128'd2;
    end

    assign puf_resp_c = puf_resp(challenge);

endmodule

// File: rtl/sap_full_system.sv
// sap_full_system: host-command security processor (cipher, hash, TRNG, PUF,
// odometer, scratch memory). Build option SAP_POCA_EN adds POCA opcode 0x2C.
// Ports: clk/rstn (sync active-low); host_instruction/host_data/sap_start
// request; sap_operation_done pulse + sap_output result; poca_* handshake.
module sap_full_system
    import sap_full_system_pkg::*;
(
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [HOST_INSTRUCT_SIZE-1:0]   host_instruction,
    input  logic [MAX_INPUT_DATA_SIZE-1:0]  host_data,
    input  logic                            sap_start,
    output logic                            sap_operation_done,
    output logic [MAX_OUTPUT_DATA_SIZE-1:0] sap_output,
    input  logic [POCA_MULT_SIZE-1:0]       poca_base_point_g,
    input  logic [POCA_SEED_SIZE-1:0]       poca_signature_gen_seed,
    input  logic [POCA_CYCLE_SIZE-1:0]      poca_signature_gen_capture_cycle,
    input  logic [POCA_MULT_SIZE-1:0]       poca_public_key_hsm,
    input  logic                            poca_public_key_hsm_received,
    input  logic                            poca_data_received,
    input  logic                            test_mode,
    input  logic [POCA_ASSET_SIZE-1:0]      poca_asset_size,
    output logic [POCA_RESP_SIZE-1:0]       poca_response,
    output logic                            poca_response_ready
);

    sap_state_e   state;
    logic [5:0]   opcode;
    logic [127:0] opnd;
    logic [31:0]  cnt;
    logic [255:0] work;
    logic [127:0] rkey;
    logic [511:0] hdata;
    logic [479:0] trng_buf;
    logic [31:0]  lfsr;
    logic [511:0] mem;

    logic [1:0]   core_op_c;
    logic [2:0]   core_round_c;
    logic [255:0] core_state_c;
    logic [127:0] core_key_c;
    logic [127:0] core_key_last_c;
    logic [63:0]  core_puf_c;
    logic [63:0]  challenge_c;
    logic         finish_c;
    logic [511:0] result_c;

    // Decrypt runs its round index downward; everything else counts up.
    always_comb begin
        core_op_c    = CR_HASH;
        core_round_c = cnt[2:0];
        if (opcode == OP_ENCRYPT) begin
            core_op_c = CR_ENC;
        end else if (opcode == OP_DECRYPT) begin
            core_op_c    = CR_DEC;
            core_round_c = 3'd3 - cnt[2:0];
        end
    end

    // Sec-PUF needs the response at latch time, before the operand register is loaded.
    assign challenge_c = (state == ST_IDLE) ? host_data[63:0] : opnd[63:0];

    sap_crypto_core u_core (
        .op_sel     (core_op_c),
        .round      (core_round_c),
        .state_in   (work),
        .key_in     (rkey),
        .hash_data  (hdata),
        .key0       (host_data[127:0]),
        .challenge  (challenge_c),
        .state_c    (core_state_c),
        .key_c      (core_key_c),
        .key_last_c (core_key_last_c),
        .puf_resp_c (core_puf_c)
    );

    // RUN completion condition and result per opcode.
    always_comb begin
        finish_c = 1'b0;
        result_c = '0;
        case (opcode)
            OP_ODOMETER: begin
                finish_c = (cnt == 32'd0);
                result_c = {504'b0, opnd[7:0]};
            end
            OP_ENCRYPT, OP_DECRYPT: begin
                finish_c = (cnt == 32'd3);
                result_c = {384'b0, core_state_c[127:0]};
            end
            OP_HASH, OP_SEC_PUF: begin
                finish_c = (cnt == 32'd7);
                result_c = {256'b0, core_state_c};
            end
            OP_TRNG: begin
                finish_c = (cnt == 32'd15);
                result_c = {trng_buf, lfsr};
            end
            OP_PUF: begin
                finish_c = 1'b1;
                result_c = {448'b0, core_puf_c};
            end
            OP_PUF_VERIFY: begin
                finish_c = 1'b1;
                result_c = {511'b0, opnd[127:64] == core_puf_c};
            end
            OP_MEM_WRITE: begin
                finish_c = 1'b1;
                result_c = sap_output;
            end
            OP_MEM_READ: begin
                finish_c = 1'b1;
                result_c = mem;
            end
`ifdef SAP_POCA_EN
            OP_POCA: finish_c = !test_mode;
`endif
            default: finish_c = 1'b1;
        endcase
    end

`ifdef SAP_POCA_EN
    logic [255:0] poca_key;
    logic         unused_poca_c;
    assign unused_poca_c = ^poca_public_key_hsm[282:256];
`else
    logic unused_poca_c;
    assign unused_poca_c = ^{poca_base_point_g, poca_signature_gen_seed,
                             poca_signature_gen_capture_cycle, poca_public_key_hsm,
                             poca_public_key_hsm_received, poca_data_received,
                             test_mode, poca_asset_size};
    assign poca_response       = '0;
    assign poca_response_ready = 1'b0;
`endif

    // Command FSM, datapath registers and free-running TRNG.
    always_ff @(posedge clk) begin
        lfsr <= lfsr_step(lfsr);
        if (!rstn) begin
            state              <= ST_IDLE;
            opcode             <= '0;
            opnd               <= '0;
            cnt                <= '0;
            work               <= '0;
            rkey               <= '0;
            hdata              <= '0;
            trng_buf           <= '0;
            lfsr               <= LFSR_SEED;
            mem                <= '0;
            sap_output         <= '0;
            sap_operation_done <= 1'b0;
`ifdef SAP_POCA_EN
            poca_key            <= '0;
            poca_response       <= '0;
            poca_response_ready <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: if (sap_start) begin
                    state  <= ST_RUN;
                    opcode <= host_instruction;
                    opnd   <= host_data[127:0];
                    work   <= {128'b0, host_data[255:128]};
                    rkey   <= (host_instruction == OP_DECRYPT) ? core_key_last_c : host_data[127:0];
                    hdata  <= host_data;
                    cnt    <= '0;
                    if (host_instruction == OP_HASH || host_instruction == OP_SEC_PUF) work <= '0;
                    if (host_instruction == OP_SEC_PUF) hdata <= {448'b0, core_puf_c};
                    if (host_instruction == OP_ODOMETER) cnt <= 32'(host_data[7:0]);
`ifdef SAP_POCA_EN
                    if (host_instruction == OP_POCA) cnt <= poca_signature_gen_capture_cycle;
`endif
                end
                ST_RUN: begin
                    cnt  <= cnt + 32'd1;
                    work <= core_state_c;
                    rkey <= core_key_c;
                    if (opcode == OP_TRNG) trng_buf <= {trng_buf[447:0], lfsr};
                    if (opcode == OP_ODOMETER) cnt <= cnt - 32'd1;
`ifdef SAP_POCA_EN
                    if (opcode == OP_POCA && test_mode) begin
                        cnt <= cnt - 32'd1;
                        if (cnt == 32'd0) begin
                            poca_response <= {poca_base_point_g ^ {155'b0, poca_signature_gen_seed},
                                              hash16(poca_signature_gen_seed, poca_asset_size)};
                            poca_response_ready <= 1'b1;
                            state <= ST_WAIT_KEY;
                        end
                    end
`endif
                    if (finish_c) begin
                        state              <= ST_DONE;
                        sap_output         <= result_c;
                        sap_operation_done <= 1'b1;
                        if (opcode == OP_MEM_WRITE) mem <= sap_output;
                    end
                end
`ifdef SAP_POCA_EN
                ST_WAIT_KEY: if (poca_public_key_hsm_received) begin
                    poca_key <= poca_public_key_hsm[255:0] ^ poca_base_point_g[255:0];
                    state    <= ST_WAIT_DATA;
                end
                ST_WAIT_DATA: if (poca_data_received) begin
                    sap_output          <= {256'b0, host_data[255:0] ^ poca_key};
                    sap_operation_done  <= 1'b1;
                    poca_response_ready <= 1'b0;
                    state               <= ST_DONE;
                end
`else
                ST_WAIT_KEY, ST_WAIT_DATA: state <= ST_IDLE;
`endif
                ST_DONE: begin
                    sap_operation_done <= 1'b0;
                    state              <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sap_full_system.sv
// Self-checking bench for sap_full_system: expected results are queued at
// stimulus time and compared when the DUT pulses sap_operation_done.
module tb_sap_full_system;

    logic         clk = 1'b0;
    logic         rstn;
    logic [5:0]   host_instruction;
    logic [511:0] host_data;
    logic         sap_start;
    logic         sap_operation_done;
    logic [511:0] sap_output;
    logic [282:0] poca_base_point_g;
    logic [127:0] poca_signature_gen_seed;
    logic [31:0]  poca_signature_gen_capture_cycle;
    logic [282:0] poca_public_key_hsm;
    logic         poca_public_key_hsm_received;
    logic         poca_data_received;
    logic         test_mode;
    logic [10:0]  poca_asset_size;
    logic [538:0] poca_response;
    logic         poca_response_ready;

    always #5 clk = ~clk;

    sap_full_system dut (
        .clk                              (clk),
        .rstn                             (rstn),
        .host_instruction                 (host_instruction),
        .host_data                        (host_data),
        .sap_start                        (sap_start),
        .sap_operation_done               (sap_operation_done),
        .sap_output                       (sap_output),
        .poca_base_point_g                (poca_base_point_g),
        .poca_signature_gen_seed          (poca_signature_gen_seed),
        .poca_signature_gen_capture_cycle (poca_signature_gen_capture_cycle),
        .poca_public_key_hsm              (poca_public_key_hsm),
        .poca_public_key_hsm_received     (poca_public_key_hsm_received),
        .poca_data_received               (poca_data_received),
        .test_mode                        (test_mode),
        .poca_asset_size                  (poca_asset_size),
        .poca_response                    (poca_response),
        .poca_response_ready              (poca_response_ready)
    );

    typedef struct {
        string        tag;
        logic [511:0] val;
        bit           chk;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [511:0] val, input bit chk);
        exp_t e;
        e.tag = tag;
        e.val = val;
        e.chk = chk;
        exp_q.push_back(e);
    endtask

    // Scoreboard: every done pulse consumes one expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (rstn && sap_operation_done) begin
            if (exp_q.size() == 0) begin
                check_eq("spurious_done", 512'(sap_operation_done), 512'd0);
            end else begin
                e = exp_q.pop_front();
                if (e.chk) check_eq(e.tag, sap_output, e.val);
            end
        end
    end

    // ---------------- reference models ----------------
    function automatic logic [127:0] rl128(input logic [127:0] x, input int n);
        logic [127:0] y = x;
        for (int i = 0; i < n; i++) y = {y[126:0], y[127]};
        return y;
    endfunction

    function automatic logic [127:0] rr128(input logic [127:0] x, input int n);
        logic [127:0] y = x;
        for (int i = 0; i < n; i++) y = {y[0], y[127:1]};
        return y;
    endfunction

    function automatic logic [127:0] enc_model(input logic [127:0] pt, input logic [127:0] k);
        logic [127:0] s = pt;
        logic [127:0] kk = k;
        for (int r = 0; r < 4; r++) begin
            s  = rl128(s ^ kk, 8);
            kk = rl128(kk, 1) ^ 128'(r);
        end
        return s;
    endfunction

    function automatic logic [127:0] dec_model(input logic [127:0] ct, input logic [127:0] k);
        logic [127:0] ks[4];
        logic [127:0] s = ct;
        ks[0] = k;
        for (int r = 0; r < 3; r++) ks[r+1] = rl128(ks[r], 1) ^ 128'(r);
        for (int r = 3; r >= 0; r--) s = rr128(s, 8) ^ ks[r];
        return s;
    endfunction

    function automatic logic [255:0] hash_model(input logic [511:0] d);
        logic [255:0] h = '0;
        logic [255:0] t;
        for (int r = 0; r < 8; r++) begin
            t = h ^ d[255:0];
            t = {t[242:0], t[255:243]};
            h = t + d[511:256];
        end
        return h;
    endfunction

    function automatic logic [63:0] puf_model(input logic [63:0] c);
        logic [63:0] x = c ^ 64'h5A5AC3C30F0F9696;
        for (int i = 0; i < int'(c[5:0]); i++) x = {x[62:0], x[63]};
        return x;
    endfunction

    function automatic logic [31:0] gal(input logic [31:0] w);
        return (w >> 1) ^ (w[0] ? 32'h80200003 : 32'd0);
    endfunction

    function automatic int trng_chain_bad(input logic [511:0] v);
        int bad = 0;
        for (int i = 0; i < 15; i++)
            if (gal(v[511-32*i -: 32]) != v[479-32*i -: 32]) bad++;
        return bad;
    endfunction

    function automatic logic [255:0] hash16_model(input logic [127:0] seed, input logic [10:0] asset);
        logic [15:0]  h = {5'b0, asset};
        logic [255:0] d;
        for (int i = 0; i < 8; i++) h = {h[14:0], h[15]} ^ seed[16*i +: 16];
        for (int i = 0; i < 16; i++) d[16*i +: 16] = h ^ 16'(i);
        return d;
    endfunction

    // Issue one command with a one-cycle start; wait (bounded) for done.
    task automatic do_op(input logic [5:0] op, input logic [511:0] data, input string tag,
                         input logic [511:0] exp, input bit chk,
                         output logic [511:0] out, output int unsigned lat);
        int unsigned t0;
        int          k;
        @(negedge clk);
        host_instruction = op;
        host_data        = data;
        sap_start        = 1'b1;
        t0               = cyc;
        push_exp(tag, exp, chk);
        @(negedge clk);
        sap_start = 1'b0;
        k = 0;
        while (!sap_operation_done && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (!sap_operation_done) begin
            check_eq({tag, "_timeout"}, 512'(sap_operation_done), 512'd1);
            exp_q.delete();
        end
        out = sap_output;
        lat = cyc - t0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] out, h1, h2, t1, t2;
        logic [127:0] pt, key, ct, pt2, key2;
        logic [63:0]  resp, c;
        int unsigned  lat;
        int           nd, k;

        rstn = 1'b0;
        host_instruction = '0;
        host_data = '0;
        sap_start = 1'b0;
        poca_base_point_g = '0;
        poca_signature_gen_seed = '0;
        poca_signature_gen_capture_cycle = '0;
        poca_public_key_hsm = '0;
        poca_public_key_hsm_received = 1'b0;
        poca_data_received = 1'b0;
        test_mode = 1'b0;
        poca_asset_size = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_output", sap_output, 512'd0);
        check_eq("rst_done", 512'(sap_operation_done), 512'd0);
        check_eq("rst_poca_ready", 512'(poca_response_ready), 512'd0);
        check_eq("rst_poca_resp", 512'(|poca_response), 512'd0);
        rstn = 1'b1;

        // Odometer
        do_op(6'h17, 512'h108, "odo8", 512'd8, 1'b1, out, lat);
        check_eq("odo8_lat", 512'(lat >= 9 && lat <= 10), 512'd1);
        do_op(6'h17, 512'h0, "odo0", 512'd0, 1'b1, out, lat);
        check_eq("odo0_lat", 512'(lat), 512'd2);

        // Cipher: known vector then a random one
        pt  = 128'hBF85BA56926B4C798501ABBA49928C55;
        key = 128'h1499325D65411CD97031755A0784CF24;
        do_op(6'h11, {256'b0, pt, key}, "enc_vec", {384'b0, enc_model(pt, key)}, 1'b1, out, lat);
        ct = out[127:0];
        do_op(6'h12, {256'b0, ct, key}, "dec_vec", {384'b0, pt}, 1'b1, out, lat);
        pt2  = {$urandom, $urandom, $urandom, $urandom};
        key2 = {$urandom, $urandom, $urandom, $urandom};
        do_op(6'h11, {256'b0, pt2, key2}, "enc_rand", {384'b0, enc_model(pt2, key2)}, 1'b1, out, lat);
        ct = out[127:0];
        do_op(6'h12, {256'b0, ct, key2}, "dec_rand", {384'b0, dec_model(ct, key2)}, 1'b1, out, lat);
        check_eq("dec_rand_identity", 512'(out[127:0]), 512'(pt2));

        // Hash twice, then mem write / read
        do_op(6'h13, {512{1'b1}}, "hash1", {256'b0, hash_model({512{1'b1}})}, 1'b1, h1, lat);
        do_op(6'h13, {512{1'b1}}, "hash2", {256'b0, hash_model({512{1'b1}})}, 1'b1, h2, lat);
        check_eq("hash_repeat", h1, h2);
        check_eq("hash_nonzero", 512'(|h1), 512'd1);
        do_op(6'h26, 512'h5, "memw", h2, 1'b1, out, lat);
        do_op(6'h2A, 512'h0, "memr", h2, 1'b1, out, lat);

        // TRNG
        do_op(6'h14, 512'h0, "trng1", 512'd0, 1'b0, t1, lat);
        do_op(6'h14, 512'h0, "trng2", 512'd0, 1'b0, t2, lat);
        check_eq("trng_differ", 512'(t1 != t2), 512'd1);
        check_eq("trng1_chain", 512'(trng_chain_bad(t1)), 512'd0);
        check_eq("trng2_chain", 512'(trng_chain_bad(t2)), 512'd0);

        // PUF, verify, sec-PUF
        c    = 64'h1;
        resp = puf_model(c);
        do_op(6'h25, {448'b0, c}, "puf", {448'b0, resp}, 1'b1, out, lat);
        do_op(6'h29, {384'b0, resp, c}, "puf_verify_ok", 512'd1, 1'b1, out, lat);
        do_op(6'h29, {384'b0, resp ^ 64'h10, c}, "puf_verify_bad", 512'd0, 1'b1, out, lat);
        c = {$urandom, $urandom};
        do_op(6'h2B, {448'b0, c}, "sec_puf", {256'b0, hash_model({448'b0, puf_model(c)})}, 1'b1, out, lat);

        // Undefined opcode, and POCA opcode when it is not active
        do_op(6'h3F, {512{1'b1}}, "undef", 512'd0, 1'b1, out, lat);
        check_eq("undef_lat", 512'(lat), 512'd2);
`ifdef SAP_POCA_EN
        test_mode = 1'b0;
`else
        test_mode = 1'b1;
`endif
        do_op(6'h2C, {512{1'b1}}, "poca_inactive", 512'd0, 1'b1, out, lat);
        check_eq("poca_inactive_ready", 512'(poca_response_ready), 512'd0);
        test_mode = 1'b0;

`ifdef SAP_POCA_EN
        // Full POCA handshake
        test_mode = 1'b1;
        poca_signature_gen_capture_cycle = 32'h1F4;
        poca_base_point_g   = 283'({$urandom, $urandom, $urandom, $urandom, $urandom,
                                    $urandom, $urandom, $urandom, $urandom});
        poca_public_key_hsm = 283'({$urandom, $urandom, $urandom, $urandom, $urandom,
                                    $urandom, $urandom, $urandom, $urandom});
        poca_signature_gen_seed = {$urandom, $urandom, $urandom, $urandom};
        poca_asset_size = 11'h2A5;
        begin
            int unsigned t0;
            logic [511:0] d;
            d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            host_instruction = 6'h2C;
            host_data = d;
            sap_start = 1'b1;
            t0 = cyc;
            push_exp("poca_out", {256'b0, d[255:0] ^ poca_public_key_hsm[255:0] ^ poca_base_point_g[255:0]}, 1'b1);
            @(negedge clk);
            sap_start = 1'b0;
            k = 0;
            while (!poca_response_ready && k < 1000) begin
                @(negedge clk);
                k++;
            end
            check_eq("poca_ready_lat", 512'((cyc - t0) >= 500 && (cyc - t0) <= 503), 512'd1);
            check_eq("poca_resp_point", 512'(poca_response[538:256]),
                     512'(poca_base_point_g ^ {155'b0, poca_signature_gen_seed}));
            check_eq("poca_resp_digest", 512'(poca_response[255:0]),
                     512'(hash16_model(poca_signature_gen_seed, poca_asset_size)));
            poca_public_key_hsm_received = 1'b1;
            @(negedge clk);
            poca_public_key_hsm_received = 1'b0;
            poca_data_received = 1'b1;
            @(negedge clk);
            poca_data_received = 1'b0;
            k = 0;
            while (!sap_operation_done && k < 20) begin
                @(negedge clk);
                k++;
            end
            check_eq("poca_done", 512'(sap_operation_done), 512'd1);
            check_eq("poca_ready_clear", 512'(poca_response_ready), 512'd0);
        end
        test_mode = 1'b0;
`endif

        // Level-sensitive start: holding start re-runs the latched command
        @(negedge clk);
        host_instruction = 6'h17;
        host_data = 512'd2;
        sap_start = 1'b1;
        push_exp("level1", 512'd2, 1'b1);
        push_exp("level2", 512'd2, 1'b1);
        nd = 0;
        k = 0;
        while (nd < 2 && k < 200) begin
            @(negedge clk);
            k++;
            if (sap_operation_done) nd++;
        end
        sap_start = 1'b0;
        check_eq("level_restarts", 512'(nd), 512'd2);
        repeat (8) @(negedge clk);

        // Reset in the middle of a hash
        @(negedge clk);
        host_instruction = 6'h13;
        host_data = {512{1'b1}};
        sap_start = 1'b1;
        @(negedge clk);
        sap_start = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        nd = 0;
        repeat (30) begin
            @(negedge clk);
            if (sap_operation_done) nd++;
        end
        check_eq("rst_mid_no_done", 512'(nd), 512'd0);
        check_eq("rst_mid_output", sap_output, 512'd0);
        do_op(6'h2A, 512'h0, "memr_after_rst", 512'd0, 1'b1, out, lat);

        repeat (3) @(negedge clk);
        check_eq("queue_drained", 512'(exp_q.size()), 512'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
